// File: rtl/wb_check_unit.sv
// rtl/wb_check_unit.sv - write-back checker: shadows WB register writes, scans against an expected table
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   start                 begin a run (accepted in IDLE/DONE)
//   halt                  end-of-program from the pipeline
//   wb_reg_write, wb_write_register, wb_write_data
//                         WB-stage register write port being snooped
//   exp_we, exp_addr, exp_data, exp_care
//                         expected-table programming (accepted in IDLE/DONE)
//   busy, done            status (RUN/SCAN, DONE)
//   pass, fail, timed_out result flags, valid in DONE
//   mismatch_cnt/reg/got/exp
//                         mismatch count and details of the lowest-index mismatch
//   cycle_count, write_count
//                         run statistics (saturating)

module wb_check_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int CYCLE_LIMIT = 90,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           halt,
    input  logic                           wb_reg_write,
    input  logic [ADDR_WIDTH-1:0]          wb_write_register,
    input  logic [DATA_WIDTH-1:0]          wb_write_data,
    input  logic                           exp_we,
    input  logic [ADDR_WIDTH-1:0]          exp_addr,
    input  logic [DATA_WIDTH-1:0]          exp_data,
    input  logic                           exp_care,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timed_out,
    output logic [$clog2(NUM_REGS+1)-1:0]  mismatch_cnt,
    output logic [ADDR_WIDTH-1:0]          mismatch_reg,
    output logic [DATA_WIDTH-1:0]          mismatch_got,
    output logic [DATA_WIDTH-1:0]          mismatch_exp,
    output logic [CNT_WIDTH-1:0]           cycle_count,
    output logic [CNT_WIDTH-1:0]           write_count
);

    localparam int MW = $clog2(NUM_REGS+1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] shadow   [NUM_REGS];
    logic [DATA_WIDTH-1:0] expected [NUM_REGS];
    logic [NUM_REGS-1:0]   care;
    logic [ADDR_WIDTH-1:0] scan_idx;

    logic                  idle_or_done;
    logic                  start_ok;
    logic                  exp_ok;
    logic                  wb_accept;
    logic [CNT_WIDTH-1:0]  next_cycle;
    logic                  limit_hit;
    logic [DATA_WIDTH-1:0] scan_got;
    logic                  scan_miss;
    logic [MW-1:0]         next_mcnt;
    logic                  scan_last;

    always_comb begin
        idle_or_done = (state == S_IDLE) || (state == S_DONE);
        start_ok     = idle_or_done && start;
        exp_ok       = idle_or_done && exp_we && (int'(exp_addr) < NUM_REGS);
        // Register 0 is hardwired zero and out-of-range indices have no shadow slot.
        wb_accept    = wb_reg_write && (wb_write_register != '0)
                       && (int'(wb_write_register) < NUM_REGS);
        next_cycle   = (cycle_count == '1) ? cycle_count : cycle_count + CNT_WIDTH'(1);
        limit_hit    = (next_cycle == CNT_WIDTH'(CYCLE_LIMIT));
        scan_got     = (scan_idx == '0) ? '0 : shadow[scan_idx];
        scan_miss    = care[scan_idx] && (scan_got != expected[scan_idx]);
        next_mcnt    = (scan_miss && (mismatch_cnt != '1)) ? mismatch_cnt + MW'(1) : mismatch_cnt;
        scan_last    = (scan_idx == ADDR_WIDTH'(NUM_REGS-1));
    end

    // Expected values survive reset; the care bits alone decide what is checked.
    always_ff @(posedge clk) begin
        if (reset && exp_ok) begin
            expected[exp_addr] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || start_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else if (state == S_RUN && wb_accept) begin
            shadow[wb_write_register] <= wb_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            care         <= '0;
            scan_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timed_out    <= 1'b0;
            mismatch_cnt <= '0;
            mismatch_reg <= '0;
            mismatch_got <= '0;
            mismatch_exp <= '0;
            cycle_count  <= '0;
            write_count  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (exp_ok) begin
                        care[exp_addr] <= exp_care;
                    end
                    if (start) begin
                        state        <= S_RUN;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        fail         <= 1'b0;
                        timed_out    <= 1'b0;
                        mismatch_cnt <= '0;
                        mismatch_reg <= '0;
                        mismatch_got <= '0;
                        mismatch_exp <= '0;
                        cycle_count  <= '0;
                        write_count  <= '0;
                    end
                end
                S_RUN: begin
                    cycle_count <= next_cycle;
                    if (wb_accept && write_count != '1) begin
                        write_count <= write_count + CNT_WIDTH'(1);
                    end
                    if (halt || limit_hit) begin
                        state     <= S_SCAN;
                        scan_idx  <= '0;
                        timed_out <= !halt;
                    end
                end
                S_SCAN: begin
                    mismatch_cnt <= next_mcnt;
                    // Zero count before this entry means this is the first mismatch.
                    if (scan_miss && mismatch_cnt == '0) begin
                        mismatch_reg <= scan_idx;
                        mismatch_got <= scan_got;
                        mismatch_exp <= expected[scan_idx];
                    end
                    scan_idx <= scan_idx + ADDR_WIDTH'(1);
                    if (scan_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (next_mcnt == '0);
                        fail  <= (next_mcnt != '0);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_check_unit.sv
// tb/tb_wb_check_unit.sv - directed self-checking bench for wb_check_unit

module tb_wb_check_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt;
    logic        wb_reg_write;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_care;
    logic        busy, done, pass, fail, timed_out;
    logic [5:0]  mismatch_cnt;
    logic [4:0]  mismatch_reg;
    logic [31:0] mismatch_got, mismatch_exp;
    logic [15:0] cycle_count, write_count;

    int total = 0;
    int bad   = 0;
    int lat;

    int          wn;
    int          wc [8];
    logic [4:0]  wr [8];
    logic [31:0] wd [8];

    always #5 clk = ~clk;

    wb_check_unit #(
        .DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .CYCLE_LIMIT(90), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register),
        .wb_write_data(wb_write_data), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_care(exp_care), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .timed_out(timed_out), .mismatch_cnt(mismatch_cnt),
        .mismatch_reg(mismatch_reg), .mismatch_got(mismatch_got),
        .mismatch_exp(mismatch_exp), .cycle_count(cycle_count), .write_count(write_count)
    );

    task automatic idle_inputs();
        start = 0; halt = 0; wb_reg_write = 0; wb_write_register = 0; wb_write_data = 0;
        exp_we = 0; exp_addr = 0; exp_data = 0; exp_care = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        @(negedge clk);
        reset = 1;
        wn = 0;
    endtask

    task automatic add_wr(input int c, input logic [4:0] r, input logic [31:0] d);
        wc[wn] = c; wr[wn] = r; wd[wn] = d; wn++;
    endtask

    task automatic program_exp(input logic [4:0] a, input logic [31:0] d, input logic c);
        exp_we = 1; exp_addr = a; exp_data = d; exp_care = c;
        @(negedge clk);
        exp_we = 0;
    endtask

    task automatic start_run();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // Drives RUN cycles 1..ncyc; halt asserted in cycle halt_at (0 = never).
    task automatic run(input int halt_at, input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            halt = (k == halt_at);
            wb_reg_write = 0;
            for (int j = 0; j < wn; j++) begin
                if (wc[j] == k) begin
                    wb_reg_write = 1; wb_write_register = wr[j]; wb_write_data = wd[j];
                end
            end
            @(negedge clk);
        end
        halt = 0;
        wb_reg_write = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        total++; if ({busy, done, pass, fail, timed_out} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, pass, fail, timed_out}); end
        total++; if ({cycle_count, write_count, mismatch_cnt} !== 38'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", cycle_count, write_count, mismatch_cnt); end
        total++; if ({mismatch_reg, mismatch_got, mismatch_exp} !== 69'd0) begin bad++; $display("FAIL reset_mismatch got=%0d/%0h/%0h exp=0/0/0", mismatch_reg, mismatch_got, mismatch_exp); end
    endtask

    task automatic test_pass_halt();
        do_reset();
        program_exp(5'd4, 32'd30, 1);
        program_exp(5'd6, 32'hFFFFFFE1, 1);
        program_exp(5'd12, 32'd1, 1);
        add_wr(1, 5'd4, 32'd30);
        add_wr(2, 5'd6, 32'hFFFFFFE1);
        add_wr(3, 5'd12, 32'd1);
        start_run();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy_after_start got=%b exp=1", busy); end
        run(20, 20);
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL t1_scan_status got=%b exp=10", {busy, done}); end
        wait_done(lat);
        total++; if (lat !== 32) begin bad++; $display("FAIL t1_scan_latency got=%0d exp=32", lat); end
        total++; if ({pass, fail, busy} !== 3'b100) begin bad++; $display("FAIL t1_result got=%b exp=100", {pass, fail, busy}); end
        total++; if (cycle_count !== 16'd20) begin bad++; $display("FAIL t1_cycle_count got=%0d exp=20", cycle_count); end
        total++; if (write_count !== 16'd3) begin bad++; $display("FAIL t1_write_count got=%0d exp=3", write_count); end
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL t1_timed_out got=%b exp=0", timed_out); end
    endtask

    task automatic test_mismatch();
        do_reset();
        program_exp(5'd11, 32'd10, 1);
        // Table write and start share a cycle: both must take effect.
        exp_we = 1; exp_addr = 5'd15; exp_data = 32'd2; exp_care = 1; start = 1;
        @(negedge clk);
        exp_we = 0; start = 0;
        add_wr(1, 5'd11, 32'd9);
        add_wr(2, 5'd15, 32'd3);
        run(5, 5);
        wait_done(lat);
        total++; if ({done, pass, fail} !== 3'b101) begin bad++; $display("FAIL t2_result got=%b exp=101", {done, pass, fail}); end
        total++; if (mismatch_cnt !== 6'd2) begin bad++; $display("FAIL t2_mismatch_cnt got=%0d exp=2", mismatch_cnt); end
        total++; if (mismatch_reg !== 5'd11) begin bad++; $display("FAIL t2_mismatch_reg got=%0d exp=11", mismatch_reg); end
        total++; if (mismatch_got !== 32'd9) begin bad++; $display("FAIL t2_mismatch_got got=%0d exp=9", mismatch_got); end
        total++; if (mismatch_exp !== 32'd10) begin bad++; $display("FAIL t2_mismatch_exp got=%0d exp=10", mismatch_exp); end
    endtask

    task automatic test_timeout();
        do_reset();
        start_run();
        run(0, 90);
        total++; if ({busy, timed_out} !== 2'b11) begin bad++; $display("FAIL t3_exit_status got=%b exp=11", {busy, timed_out}); end
        wait_done(lat);
        total++; if (lat !== 32) begin bad++; $display("FAIL t3_scan_latency got=%0d exp=32", lat); end
        total++; if (cycle_count !== 16'd90) begin bad++; $display("FAIL t3_cycle_count got=%0d exp=90", cycle_count); end
        total++; if ({pass, fail, timed_out} !== 3'b101) begin bad++; $display("FAIL t3_result got=%b exp=101", {pass, fail, timed_out}); end
    endtask

    task automatic test_last_write();
        do_reset();
        program_exp(5'd0, 32'd0, 1);
        program_exp(5'd17, 32'd160, 1);
        add_wr(1, 5'd0, 32'd5);
        add_wr(2, 5'd17, 32'd80);
        add_wr(3, 5'd17, 32'd160);
        start_run();
        run(4, 4);
        wait_done(lat);
        total++; if ({done, pass, fail} !== 3'b110) begin bad++; $display("FAIL t4_result got=%b exp=110", {done, pass, fail}); end
        total++; if (write_count !== 16'd2) begin bad++; $display("FAIL t4_write_count got=%0d exp=2", write_count); end
        total++; if (cycle_count !== 16'd4) begin bad++; $display("FAIL t4_cycle_count got=%0d exp=4", cycle_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        program_exp(5'd9, 32'd5, 1);
        add_wr(3, 5'd9, 32'd5);
        start_run();
        run(3, 3);
        // Attempted table overwrite while scanning must be ignored.
        exp_we = 1; exp_addr = 5'd9; exp_data = 32'd7; exp_care = 1;
        @(negedge clk);
        exp_we = 0;
        wait_done(lat);
        total++; if (lat !== 31) begin bad++; $display("FAIL t5_scan_latency got=%0d exp=31", lat); end
        total++; if ({done, pass, write_count} !== {2'b11, 16'd1}) begin bad++; $display("FAIL t5_result got=%b/%b/%0d exp=1/1/1", done, pass, write_count); end
        // Restart from DONE: counters reset and the table still holds $9=5.
        start_run();
        total++; if ({busy, done, cycle_count} !== {2'b10, 16'd0}) begin bad++; $display("FAIL t5_restart got=%b/%b/%0d exp=1/0/0", busy, done, cycle_count); end
        run(3, 3);
        wait_done(lat);
        total++; if ({pass, cycle_count} !== {1'b1, 16'd3}) begin bad++; $display("FAIL t5_rerun got=%b/%0d exp=1/3", pass, cycle_count); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        program_exp(5'd3, 32'd1, 1);
        add_wr(1, 5'd3, 32'd2);
        add_wr(2, 5'd5, 32'd7);
        start_run();
        run(6, 6);
        repeat (10) @(negedge clk);
        total++; if ({busy, mismatch_cnt, mismatch_reg} !== {1'b1, 6'd1, 5'd3}) begin bad++; $display("FAIL t6_pre_reset got=%b/%0d/%0d exp=1/1/3", busy, mismatch_cnt, mismatch_reg); end
        reset = 0;
        @(negedge clk);
        total++; if ({busy, done, pass, fail, timed_out} !== 5'b0) begin bad++; $display("FAIL t6_flags got=%b exp=00000", {busy, done, pass, fail, timed_out}); end
        total++; if ({cycle_count, write_count, mismatch_cnt, mismatch_reg, mismatch_got, mismatch_exp} !== 107'd0) begin bad++; $display("FAIL t6_values got=%0d/%0d/%0d/%0d exp=0/0/0/0", cycle_count, write_count, mismatch_cnt, mismatch_got); end
        reset = 1;
        wn = 0;
        start_run();
        run(4, 4);
        wait_done(lat);
        total++; if ({done, pass, fail} !== 3'b110) begin bad++; $display("FAIL t6_after_reset got=%b exp=110", {done, pass, fail}); end
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        wn = 0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1;
        test_pass_halt();
        test_mismatch();
        test_timeout();
        test_last_write();
        test_back_to_back();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
